// File: rtl/bpsk_symbol_rx.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_symbol_rx
// Description : BPSK integrate-and-dump receiver. Finds the sync word, then
//               presents one codeword per frame on a valid/ready register.
//               Optional feature macro: RX_PARITY_EN (even-parity bit per frame).
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_symbol_rx #(
  parameter int                     SAMPLE_W  = 8,
  parameter int                     SPS       = 4,
  parameter int                     WORD_W    = 12,
  parameter int                     SYNC_LEN  = 8,
  parameter logic [SYNC_LEN-1:0]    SYNC_WORD = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic        [WORD_W-1:0]   word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       locked,
  output logic                       overflow,
  output logic                       parity_err
);

  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = SAMPLE_W + CNT_W;
`ifdef RX_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  localparam int BCNT_W = $clog2(FRAME_W + 1);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] PAYLOAD = 1'b1;

  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    sum;
  logic                       bit_stb, bit_val;

  logic        [0:0]          state_q, state_d;
  logic        [SYNC_LEN-1:0] hist_q, hist_d, hist_next;
  logic        [FRAME_W-1:0]  shreg_q, shreg_d, frame_next;
  logic        [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                       complete;
  logic                       par_calc;

  logic        [WORD_W-1:0]   word_q, word_d;
  logic                       valid_q, valid_d;
  logic                       ovf_q, ovf_d;
  logic                       par_q, par_d;

  // Sum includes the current sample so the decision is made on its own edge.
  assign sum        = acc_q + {{CNT_W{sample_in[SAMPLE_W-1]}}, sample_in};
  assign bit_stb    = sample_valid && (cnt_q == CNT_W'(SPS - 1));
  assign bit_val    = ~sum[ACC_W-1];
  assign hist_next  = {hist_q[SYNC_LEN-2:0], bit_val};
  assign frame_next = {shreg_q[FRAME_W-2:0], bit_val};

`ifdef RX_PARITY_EN
  assign par_calc = ^frame_next;
`else
  assign par_calc = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (sample_valid) begin
      if (bit_stb) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = sum;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    shreg_d  = shreg_q;
    bcnt_d   = bcnt_q;
    complete = 1'b0;
    if (bit_stb) begin
      case (state_q)
        HUNT: begin
          if (hist_next == SYNC_WORD) begin
            state_d = PAYLOAD;
            hist_d  = '0;
            bcnt_d  = '0;
          end else begin
            hist_d = hist_next;
          end
        end
        default: begin
          shreg_d = frame_next;
          bcnt_d  = bcnt_q + BCNT_W'(1);
          if (bcnt_q == BCNT_W'(FRAME_W - 1)) begin
            complete = 1'b1;
            state_d  = HUNT;
          end
        end
      endcase
    end
  end

  // A completed word may only replace word_out if the slot is free or
  // being drained in this very cycle; otherwise it is dropped.
  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    par_d   = par_q;
    if (complete && (!valid_q || word_ready)) begin
      word_d  = frame_next[FRAME_W-1 -: WORD_W];
      valid_d = 1'b1;
      par_d   = par_calc;
    end else begin
      if (complete) begin
        ovf_d = 1'b1;
      end
      if (valid_q && word_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      state_q <= HUNT;
      hist_q  <= '0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      state_q <= state_d;
      hist_q  <= hist_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      par_q   <= par_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign locked     = (state_q == PAYLOAD);
  assign overflow   = ovf_q;
  assign parity_err = par_q;

endmodule
`default_nettype wire

// File: tb/tb_bpsk_symbol_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_symbol_rx
// Description : Directed self-checking bench for bpsk_symbol_rx (both builds
//               of the RX_PARITY_EN feature macro).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bpsk_symbol_rx;

  logic              clk;
  logic              reset;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic [11:0]       word_out;
  logic              word_valid;
  logic              word_ready;
  logic              locked;
  logic              overflow;
  logic              parity_err;

  int n_checks;
  int n_errors;
  int hs_count;
  logic [11:0] last_word;
  int hs_base;

  bpsk_symbol_rx #(
    .SAMPLE_W (8),
    .SPS      (4),
    .WORD_W   (12),
    .SYNC_LEN (8),
    .SYNC_WORD(8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .locked      (locked),
    .overflow    (overflow),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every accepted handshake.
  initial begin
    hs_count  = 0;
    last_word = '0;
  end
  always @(posedge clk) begin
    if (reset && word_valid && word_ready) begin
      hs_count  <= hs_count + 1;
      last_word <= word_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send_sample(input int v);
    @(negedge clk);
    sample_in    = 8'(v);
    sample_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
    end
  endtask

  // mode 0: clean +-64; mode 1: noisy (sum +-40); mode 2: sum 0 for 1, sum -1 for 0
  task automatic send_bit(input logic b, input int mode);
    case (mode)
      1: begin
        if (b) begin send_sample(100); send_sample(-20); send_sample(-20); send_sample(-20); end
        else   begin send_sample(-100); send_sample(20); send_sample(20); send_sample(20); end
      end
      2: begin
        if (b) begin send_sample(64); send_sample(-64); send_sample(64); send_sample(-64); end
        else   begin send_sample(-1); send_sample(0); send_sample(0); send_sample(0); end
      end
      default: for (int i = 0; i < 4; i++) send_sample(b ? 64 : -64);
    endcase
  endtask

  task automatic send_bits(input logic [31:0] val, input int n, input int mode);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i], mode);
  endtask

  task automatic send_par(input logic [11:0] w, input logic bad, input int mode);
`ifdef RX_PARITY_EN
    send_bit((^w) ^ bad, mode);
`else
    if (bad) send_bit(1'b0, mode);
`endif
  endtask

  task automatic send_frame(input logic [11:0] w, input logic bad, input int mode);
    send_bits(32'hA5, 8, mode);
    send_bits({20'd0, w}, 12, mode);
    send_par(w, bad, mode);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    word_ready   = 1'b0;

    // Reset with random samples
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample_in    = 8'($urandom_range(0, 255));
      sample_valid = 1'b1;
    end
    @(negedge clk);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_par", 32'(parity_err), 32'd0);
    reset        = 1'b1;
    sample_valid = 1'b0;
    idle(2);

    // Basic frame with latency and locked checks
    word_ready = 1'b1;
    hs_base    = hs_count;
    send_bits(32'hA5, 8, 0);
    idle(1);
    chk("basic_lock_start", 32'(locked), 32'd1);
    send_bits(32'h17, 6, 0);
    chk("basic_lock_mid", 32'(locked), 32'd1);
    send_bits(32'h03, 6, 0);
    send_par(12'h5C3, 1'b0, 0);
    chk("basic_valid_early", 32'(word_valid), 32'd0);
    idle(1);
    chk("basic_valid", 32'(word_valid), 32'd1);
    chk("basic_word", 32'(word_out), 32'h5C3);
    chk("basic_unlock", 32'(locked), 32'd0);
    chk("basic_par", 32'(parity_err), 32'd0);
    idle(1);
    chk("basic_valid_drop", 32'(word_valid), 32'd0);
    chk("basic_hs", 32'(hs_count - hs_base), 32'd1);

    // False sync patterns before the real one
    hs_base = hs_count;
    send_bits(32'hA4, 8, 0);
    send_bits(32'h00, 8, 0);
    chk("fsync_nolock", 32'(locked), 32'd0);
    send_frame(12'h0FF, 1'b0, 0);
    idle(3);
    chk("fsync_hs", 32'(hs_count - hs_base), 32'd1);
    chk("fsync_word", 32'(last_word), 32'h0FF);

    // Overflow with back-to-back frames
    word_ready = 1'b0;
    hs_base    = hs_count;
    send_frame(12'h123, 1'b0, 0);
    send_frame(12'h456, 1'b0, 0);
    idle(2);
    chk("ovf_valid", 32'(word_valid), 32'd1);
    chk("ovf_word", 32'(word_out), 32'h123);
    chk("ovf_flag", 32'(overflow), 32'd1);
    word_ready = 1'b1;
    idle(1);
    chk("ovf_drain", 32'(word_valid), 32'd0);
    chk("ovf_hs", 32'(hs_count - hs_base), 32'd1);
    chk("ovf_hs_word", 32'(last_word), 32'h123);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Noisy sync, then reset mid-payload
    hs_base = hs_count;
    send_bits(32'hA5, 8, 1);
    idle(1);
    chk("noisy_lock", 32'(locked), 32'd1);
    send_bits(32'h15, 5, 1);
    @(negedge clk);
    sample_valid = 1'b0;
    reset        = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mrst_locked", 32'(locked), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_valid", 32'(word_valid), 32'd0);
    send_frame(12'h3A7, 1'b0, 2);
    idle(1);
    chk("zsum_valid", 32'(word_valid), 32'd1);
    chk("zsum_word", 32'(word_out), 32'h3A7);
    idle(2);
    chk("mrst_hs", 32'(hs_count - hs_base), 32'd1);

    // Parity error frame; word is still delivered
    word_ready = 1'b0;
    send_frame(12'h5C3, 1'b1, 0);
    idle(1);
    chk("perr_word", 32'(word_out), 32'h5C3);
`ifdef RX_PARITY_EN
    chk("perr_flag", 32'(parity_err), 32'd1);
`else
    chk("perr_flag", 32'(parity_err), 32'd0);
`endif
    word_ready = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
